ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: ADDR_W, 32, address width of requests and of mem_a.
REQ-003 Parameter: WORD_W, 32, width of request and response data.
REQ-004 The block SHALL have these ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous reset, active low
- io_buffer_full  in  1  uart buffer full
- rollback_in  in  1  ROB rollback pulse
- fet_request_in  in  1  fetch request; held until ready
- fet_address_in  in  ADDR_W  fetch address
- fet_ready_out  out  1  one-cycle fetch done pulse
- fet_instruction_out  out  WORD_W  fetched word
- lsb_request_in  in  1  load/store request; held until ready
- lsb_rw_signal_in  in  1  1 = write
- lsb_address_in  in  ADDR_W  byte address
- lsb_goal_in  in  3  size: 1, 2 or 4 bytes
- lsb_data_in  in  WORD_W  store data
- lsb_ready_out  out  1  one-cycle done pulse
- lsb_data_out  out  WORD_W  load data
- mem_din  in  8  RAM read byte, valid one cycle after address
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM address
- mem_wr  out  1  1 = write

Function
REQ-005 States SHALL be IDLE, READ, WRITE, IO_WAIT; all memory outputs SHALL be registered.
REQ-006 In IDLE, with no rollback, a pending request SHALL be granted at the edge; address, size, rw and data are latched at grant.
REQ-007 Without RAM_ARB_RR_EN, LSB SHALL have fixed priority over fetch.
REQ-008 Fetch SHALL always be a 4-byte read; LSB size 1/2/4 from lsb_goal_in; any other goal value SHALL be treated as 1 byte.
REQ-009 Byte k SHALL be driven at address base+k, little-endian, k = 0..N-1.
REQ-010 A read of N bytes SHALL sample byte k at edge k+2 after grant and pulse ready at edge N+1; unused upper bytes SHALL be zero.
REQ-011 A write of N bytes SHALL drive byte k with mem_wr=1 in the cycle after edge k and pulse ready at edge N.
REQ-012 The FSM SHALL return to IDLE on the ready edge; the next grant is at the following edge at the earliest.
REQ-013 A write with mem_a[17:16]==2'b11 SHALL enter IO_WAIT with mem_wr=0 while io_buffer_full is high, and SHALL hold one extra idle cycle after the IO byte is written.
REQ-014 rollback_in in READ SHALL abort the read at that edge: IDLE, no ready, mem_a=0.
REQ-015 rollback_in SHALL NOT abort WRITE or IO_WAIT, since stores are already committed.
REQ-016 rollback_in in IDLE SHALL block the grant for that edge.
REQ-017 When not driving a byte, the block SHALL hold mem_wr=0, mem_a=0 and mem_dout=0.
REQ-018 Ready outputs SHALL be high for exactly one cycle, and the two ready outputs SHALL never be high together.

Reset
REQ-019 While rst is low the FSM SHALL be IDLE and every output zero: mem_a, mem_dout, mem_wr, both ready signals and both data outputs.
REQ-020 Reset mid-transaction SHALL discard the transaction; no ready is issued after reset releases.

Configuration
REQ-021 With RAM_ARB_RR_EN defined, on simultaneous requests the grant SHALL go to the requester not granted last; last-grant resets to fetch, so LSB wins first.
REQ-022 Without RAM_ARB_RR_EN, the last-grant register SHALL be absent and REQ-007 applies.

Structure
REQ-023 Package ram_arb_pkg SHALL hold the state enum, the byte-count width, the IO_PREFIX 2'b11 constant and the size codes.
REQ-024 Grant selection SHALL be sub-module ram_arb_grant, combinational, containing the optional round-robin last-grant flop.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Fetch 0x1000 with RAM bytes 13 05 00 00 -> mem_a 0x1000..0x1003, fet_ready at edge 5, fet_instruction_out 0x00000513.
- LSB SB to 0x30000 data 0x41 with io_buffer_full high 3 cycles -> mem_wr=0 for those cycles, then one write of 0x41, lsb_ready, one idle cycle.
- Fetch and LSB LH 0x2002 requested together -> LSB first, data 0x0000BEEF for bytes EF BE; fetch granted next.
- Rollback at edge 2 of a fetch -> no fet_ready, FSM IDLE, mem_a 0.
- Rollback during SW 0x0000_0100 data 0xDEADBEEF -> all 4 bytes written, lsb_ready at edge 4.
- RAM_ARB_RR_EN, both requesting continuously -> grants alternate LSB, fetch, LSB; without the macro, LSB always wins.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter: FSM states, the
// byte counter width, the IO address prefix and the LSB size codes.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        IO_WAIT = 2'd3
    } arb_state_t;

    // Wide enough to count edges up to N+1 for a 4-byte read.
    localparam int CNT_W = 3;

    // mem_a[17:16] of a write that targets the uart.
    localparam logic [1:0] IO_PREFIX = 2'b11;

    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    // Byte count for an LSB size code; anything unrecognised is one byte.
    function automatic logic [CNT_W-1:0] size_bytes(input logic [2:0] goal);
        case (goal)
            SZ_HALF: return CNT_W'(2);
            SZ_WORD: return CNT_W'(4);
            default: return CNT_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/ram_arb_grant.sv
// Grant selection between the fetch and LSB requesters. Purely combinational
// in the default build (LSB has fixed priority). With RAM_ARB_RR_EN defined a
// last-grant flop alternates the winner when both request together.
module ram_arb_grant (
`ifdef RAM_ARB_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic grant_take,
`endif
    input  logic fet_req,
    input  logic lsb_req,
    output logic gnt_fet,
    output logic gnt_lsb
);
    import ram_arb_pkg::*;

`ifdef RAM_ARB_RR_EN
    // Remembers who won the last grant; resets to fetch so LSB wins first.
    logic last_lsb;

    // Update the last-grant record only on an edge where a grant is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_lsb <= 1'b0;
        else if (grant_take)
            last_lsb <= gnt_lsb;
    end

    // On a tie, the requester that did not win last time gets the port.
    always_comb begin
        gnt_lsb = lsb_req && !(fet_req && last_lsb);
        gnt_fet = fet_req && !gnt_lsb;
    end
`else
    // LSB always beats fetch.
    always_comb begin
        gnt_lsb = lsb_req;
        gnt_fet = fet_req && !lsb_req;
    end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Single byte-wide RAM port shared by instruction fetch and the load/store
// buffer. Requests are serialised into little-endian byte accesses; every
// memory-side output is registered. Optional round-robin arbitration is
// enabled with the RAM_ARB_RR_EN macro.
module ram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_buffer_full,
    input  logic              rollback_in,
    input  logic              fet_request_in,
    input  logic [ADDR_W-1:0] fet_address_in,
    output logic              fet_ready_out,
    output logic [WORD_W-1:0] fet_instruction_out,
    input  logic              lsb_request_in,
    input  logic              lsb_rw_signal_in,
    input  logic [ADDR_W-1:0] lsb_address_in,
    input  logic [2:0]        lsb_goal_in,
    input  logic [WORD_W-1:0] lsb_data_in,
    output logic              lsb_ready_out,
    output logic [WORD_W-1:0] lsb_data_out,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);
    import ram_arb_pkg::*;

    arb_state_t        state, state_n;
    logic [CNT_W-1:0]  cyc, cyc_n;        // READ: edges since grant; WRITE: next byte index
    logic [CNT_W-1:0]  nbytes, nbytes_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [WORD_W-1:0] wdata, wdata_n;
    logic [WORD_W-1:0] rdata, rdata_n;
    logic              is_lsb, is_lsb_n;
    logic              io_cool, io_cool_n; // one blocked IDLE edge after an IO write
    logic              grant_rw;

    logic [ADDR_W-1:0] mem_a_n;
    logic [7:0]        mem_dout_n;
    logic              mem_wr_n;
    logic              fet_rdy_n, lsb_rdy_n;
    logic [WORD_W-1:0] fet_instr_n, lsb_data_n;

    logic              gnt_fet, gnt_lsb, take, is_io;
    logic [CNT_W-1:0]  sidx;
    logic [7:0]        wbyte;

    assign take  = (state == IDLE) && !rollback_in && !io_cool && (gnt_fet || gnt_lsb);
    assign is_io = (base[17:16] == IO_PREFIX);
    assign sidx  = cyc - CNT_W'(2);
    assign wbyte = 8'(wdata >> {cyc, 3'b000});

    ram_arb_grant u_grant (
`ifdef RAM_ARB_RR_EN
        .clk        (clk),
        .rst        (rst),
        .grant_take (take),
`endif
        .fet_req    (fet_request_in),
        .lsb_req    (lsb_request_in),
        .gnt_fet    (gnt_fet),
        .gnt_lsb    (gnt_lsb)
    );

    // Next-state and next-output logic; memory outputs idle at zero by default.
    always_comb begin
        state_n     = state;
        cyc_n       = cyc;
        nbytes_n    = nbytes;
        base_n      = base;
        wdata_n     = wdata;
        rdata_n     = rdata;
        is_lsb_n    = is_lsb;
        io_cool_n   = 1'b0;
        grant_rw    = 1'b0;
        mem_a_n     = '0;
        mem_dout_n  = '0;
        mem_wr_n    = 1'b0;
        fet_rdy_n   = 1'b0;
        lsb_rdy_n   = 1'b0;
        fet_instr_n = fet_instruction_out;
        lsb_data_n  = lsb_data_out;

        case (state)
            IDLE: begin
                if (take) begin
                    rdata_n = '0;
                    cyc_n   = CNT_W'(1);
                    if (gnt_lsb) begin
                        base_n   = lsb_address_in;
                        nbytes_n = size_bytes(lsb_goal_in);
                        wdata_n  = lsb_data_in;
                        is_lsb_n = 1'b1;
                        grant_rw = lsb_rw_signal_in;
                    end else begin
                        base_n   = fet_address_in;
                        nbytes_n = CNT_W'(4);
                        is_lsb_n = 1'b0;
                    end
                    if (!grant_rw) begin
                        state_n = READ;
                        mem_a_n = base_n;
                    end else if ((base_n[17:16] == IO_PREFIX) && io_buffer_full) begin
                        state_n = IO_WAIT;
                        cyc_n   = '0;
                    end else begin
                        state_n    = WRITE;
                        mem_a_n    = base_n;
                        mem_dout_n = lsb_data_in[7:0];
                        mem_wr_n   = 1'b1;
                    end
                end
            end

            READ: begin
                if (rollback_in) begin
                    state_n = IDLE;
                end else begin
                    cyc_n = cyc + CNT_W'(1);
                    if (cyc < nbytes)
                        mem_a_n = base + ADDR_W'(cyc);
                    // mem_din carries the byte addressed two edges earlier
                    if (cyc >= CNT_W'(2))
                        rdata_n = rdata | (WORD_W'(mem_din) << {sidx, 3'b000});
                    if (cyc == nbytes + CNT_W'(1)) begin
                        state_n = IDLE;
                        if (is_lsb) begin
                            lsb_rdy_n  = 1'b1;
                            lsb_data_n = rdata_n;
                        end else begin
                            fet_rdy_n   = 1'b1;
                            fet_instr_n = rdata_n;
                        end
                    end
                end
            end

            WRITE: begin
                if (cyc == nbytes) begin
                    state_n   = IDLE;
                    lsb_rdy_n = 1'b1;
                    io_cool_n = is_io;
                end else if (is_io && io_buffer_full) begin
                    state_n = IO_WAIT;
                end else begin
                    mem_a_n    = base + ADDR_W'(cyc);
                    mem_dout_n = wbyte;
                    mem_wr_n   = 1'b1;
                    cyc_n      = cyc + CNT_W'(1);
                end
            end

            IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_n    = WRITE;
                    mem_a_n    = base + ADDR_W'(cyc);
                    mem_dout_n = wbyte;
                    mem_wr_n   = 1'b1;
                    cyc_n      = cyc + CNT_W'(1);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset discards any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            cyc                 <= '0;
            nbytes              <= '0;
            base                <= '0;
            wdata               <= '0;
            rdata               <= '0;
            is_lsb              <= 1'b0;
            io_cool             <= 1'b0;
            mem_a               <= '0;
            mem_dout            <= '0;
            mem_wr              <= 1'b0;
            fet_ready_out       <= 1'b0;
            lsb_ready_out       <= 1'b0;
            fet_instruction_out <= '0;
            lsb_data_out        <= '0;
        end else begin
            state               <= state_n;
            cyc                 <= cyc_n;
            nbytes              <= nbytes_n;
            base                <= base_n;
            wdata               <= wdata_n;
            rdata               <= rdata_n;
            is_lsb              <= is_lsb_n;
            io_cool             <= io_cool_n;
            mem_a               <= mem_a_n;
            mem_dout            <= mem_dout_n;
            mem_wr              <= mem_wr_n;
            fet_ready_out       <= fet_rdy_n;
            lsb_ready_out       <= lsb_rdy_n;
            fet_instruction_out <= fet_instr_n;
            lsb_data_out        <= lsb_data_n;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. Edge 0 is the grant edge; outputs are
// sampled 1 time unit after each rising edge. Build with RAM_ARB_RR_EN to
// exercise the round-robin expectations.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_buffer_full, rollback_in;
    logic        fet_request_in;
    logic [31:0] fet_address_in;
    logic        fet_ready_out;
    logic [31:0] fet_instruction_out;
    logic        lsb_request_in, lsb_rw_signal_in;
    logic [31:0] lsb_address_in;
    logic [2:0]  lsb_goal_in;
    logic [31:0] lsb_data_in;
    logic        lsb_ready_out;
    logic [31:0] lsb_data_out;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int checks = 0;
    int errors = 0;
    int n;

    ram_port_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .io_buffer_full      (io_buffer_full),
        .rollback_in         (rollback_in),
        .fet_request_in      (fet_request_in),
        .fet_address_in      (fet_address_in),
        .fet_ready_out       (fet_ready_out),
        .fet_instruction_out (fet_instruction_out),
        .lsb_request_in      (lsb_request_in),
        .lsb_rw_signal_in    (lsb_rw_signal_in),
        .lsb_address_in      (lsb_address_in),
        .lsb_goal_in         (lsb_goal_in),
        .lsb_data_in         (lsb_data_in),
        .lsb_ready_out       (lsb_ready_out),
        .lsb_data_out        (lsb_data_out),
        .mem_din             (mem_din),
        .mem_dout            (mem_dout),
        .mem_a               (mem_a),
        .mem_wr              (mem_wr)
    );

    always #5 clk = ~clk;

    // RAM contents seen by reads
    function automatic logic [7:0] ram_byte(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001: return 8'h05;
            32'h2002: return 8'hEF;
            32'h2003: return 8'hBE;
            default:  return 8'h00;
        endcase
    endfunction

    // Synchronous RAM read: data valid the cycle after the address
    always @(posedge clk) mem_din <= ram_byte(mem_a);

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] s1_a [6] = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h0, 32'h0};
    logic [31:0] s3_a [4] = '{32'h2002, 32'h2003, 32'h0, 32'h0};
    logic [31:0] s5_a [4] = '{32'h100, 32'h101, 32'h102, 32'h103};
    logic [7:0]  s5_d [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef RAM_ARB_RR_EN
    logic [31:0] s6_g [3] = '{32'h2002, 32'h1000, 32'h2002};
`else
    logic [31:0] s6_g [3] = '{32'h2002, 32'h2002, 32'h2002};
`endif

    initial begin
        rst = 1'b0;
        io_buffer_full = 1'b0; rollback_in = 1'b0;
        fet_request_in = 1'b0; fet_address_in = '0;
        lsb_request_in = 1'b0; lsb_rw_signal_in = 1'b0; lsb_address_in = '0;
        lsb_goal_in = '0; lsb_data_in = '0;

        // Reset state
        step; step;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'h0);
        chk("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
        chk("rst_fet_rdy", {31'b0, fet_ready_out}, 32'h0);
        chk("rst_lsb_rdy", {31'b0, lsb_ready_out}, 32'h0);
        chk("rst_fet_instr", fet_instruction_out, 32'h0);
        chk("rst_lsb_data", lsb_data_out, 32'h0);
        rst = 1'b1;
        step;

        // Fetch 0x1000: bytes 13 05 00 00, ready at edge 5
        fet_address_in = 32'h1000; fet_request_in = 1'b1;
        for (int e = 0; e < 6; e++) begin
            step;
            chk("s1_mem_a", mem_a, s1_a[e]);
            chk("s1_mem_wr", {31'b0, mem_wr}, 32'h0);
            chk("s1_fet_rdy", {31'b0, fet_ready_out}, {31'b0, e == 5});
        end
        fet_request_in = 1'b0;
        chk("s1_instr", fet_instruction_out, 32'h0000_0513);

        // Fetch and LH 0x2002 together: LSB first, then fetch
        lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b0;
        lsb_address_in = 32'h2002; lsb_goal_in = 3'd2;
        fet_request_in = 1'b1;
        for (int e = 0; e < 4; e++) begin
            step;
            chk("s3_mem_a", mem_a, s3_a[e]);
            chk("s3_lsb_rdy", {31'b0, lsb_ready_out}, {31'b0, e == 3});
            chk("s3_fet_rdy", {31'b0, fet_ready_out}, 32'h0);
        end
        lsb_request_in = 1'b0;
        chk("s3_lsb_data", lsb_data_out, 32'h0000_BEEF);
        step;
        chk("s3_fet_grant", mem_a, 32'h1000);
        for (int e = 1; e < 6; e++) step;
        chk("s3_fet_rdy_end", {31'b0, fet_ready_out}, 32'h1);
        chk("s3_lsb_rdy_end", {31'b0, lsb_ready_out}, 32'h0);
        fet_request_in = 1'b0;

        // Rollback at edge 2 of a fetch, then rollback in IDLE blocks a grant
        fet_request_in = 1'b1;
        step;
        chk("s4_grant", mem_a, 32'h1000);
        step;
        rollback_in = 1'b1;
        step;
        chk("s4_abort_a", mem_a, 32'h0);
        chk("s4_abort_rdy", {31'b0, fet_ready_out}, 32'h0);
        step;
        chk("s4_blocked_a", mem_a, 32'h0);
        chk("s4_blocked_rdy", {31'b0, fet_ready_out}, 32'h0);
        rollback_in = 1'b0;
        step;
        chk("s4_regrant", mem_a, 32'h1000);
        for (int e = 1; e < 6; e++) step;
        chk("s4_refetch_rdy", {31'b0, fet_ready_out}, 32'h1);
        fet_request_in = 1'b0;

        // SW 0x100 0xDEADBEEF with rollback asserted after the grant
        lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b1;
        lsb_address_in = 32'h100; lsb_goal_in = 3'd4; lsb_data_in = 32'hDEAD_BEEF;
        for (int e = 0; e < 4; e++) begin
            step;
            rollback_in = 1'b1;
            chk("s5_mem_a", mem_a, s5_a[e]);
            chk("s5_dout", {24'b0, mem_dout}, {24'b0, s5_d[e]});
            chk("s5_wr", {31'b0, mem_wr}, 32'h1);
            chk("s5_rdy_early", {31'b0, lsb_ready_out}, 32'h0);
        end
        step;
        chk("s5_rdy", {31'b0, lsb_ready_out}, 32'h1);
        chk("s5_wr_end", {31'b0, mem_wr}, 32'h0);
        lsb_request_in = 1'b0; rollback_in = 1'b0;

        // SB 0x30000 0x41 with the uart buffer full for 3 cycles
        lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b1;
        lsb_address_in = 32'h0003_0000; lsb_goal_in = 3'd1; lsb_data_in = 32'h41;
        io_buffer_full = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step;
            chk("s2_wait_wr", {31'b0, mem_wr}, 32'h0);
            chk("s2_wait_a", mem_a, 32'h0);
        end
        io_buffer_full = 1'b0;
        step;
        chk("s2_io_a", mem_a, 32'h0003_0000);
        chk("s2_io_dout", {24'b0, mem_dout}, 32'h41);
        chk("s2_io_wr", {31'b0, mem_wr}, 32'h1);
        step;
        chk("s2_rdy", {31'b0, lsb_ready_out}, 32'h1);
        chk("s2_wr_off", {31'b0, mem_wr}, 32'h0);
        lsb_request_in = 1'b0;
        fet_address_in = 32'h1000; fet_request_in = 1'b1;
        step;
        chk("s2_idle_a", mem_a, 32'h0);
        chk("s2_rdy_once", {31'b0, lsb_ready_out}, 32'h0);
        step;
        chk("s2_next_grant", mem_a, 32'h1000);
        for (int e = 1; e < 6; e++) step;
        chk("s2_fet_rdy", {31'b0, fet_ready_out}, 32'h1);
        chk("s2_fet_instr", fet_instruction_out, 32'h0000_0513);

        // Both requesting continuously; LSB goal 3 is treated as one byte
        lsb_request_in = 1'b1; lsb_rw_signal_in = 1'b0;
        lsb_address_in = 32'h2002; lsb_goal_in = 3'd3;
        for (int g = 0; g < 3; g++) begin
            n = 0;
            while (mem_a == 32'h0 && n < 12) begin step; n++; end
            chk("s6_grant", mem_a, s6_g[g]);
            n = 0;
            while (!(fet_ready_out || lsb_ready_out) && n < 12) begin step; n++; end
            chk("s6_done", {31'b0, fet_ready_out || lsb_ready_out}, 32'h1);
            if (g == 0) chk("s6_lb_data", lsb_data_out, 32'h0000_00EF);
        end
        lsb_request_in = 1'b0; fet_request_in = 1'b0;
        step;

        // Reset mid-fetch discards the transaction
        fet_address_in = 32'h1000; fet_request_in = 1'b1;
        step; step;
        chk("s7_busy_a", mem_a, 32'h1001);
        rst = 1'b0;
        #1;
        chk("s7_async_a", mem_a, 32'h0);
        fet_request_in = 1'b0;
        step;
        rst = 1'b1;
        for (int e = 0; e < 7; e++) begin
            step;
            chk("s7_no_rdy", {31'b0, fet_ready_out}, 32'h0);
            chk("s7_idle_a", mem_a, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
